// File: rtl/fifo_pkg.sv
// Constants and state encoding shared by the read- and write-side FIFO controllers.
// Default geometry is a 16-entry array addressed by a 5-bit pointer with wrap bit.
package fifo_pkg;

    localparam int FIFO_DEPTH    = 16;
    localparam int FIFO_PTR_W    = 5;
    localparam int FIFO_AE_LEVEL = 2;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        UNDER  = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/fifo_occupancy_counter.sv
// Occupancy counter with registered empty / almost-empty flags, saturating at DEPTH.
// Latency: flags and count reflect inc/dec one cycle after the sampling edge.
// Backpressure: none; callers only decrement when non-empty.
module fifo_occupancy_counter
    import fifo_pkg::*;
#(
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int PTR_W    = FIFO_PTR_W,
    parameter int AE_LEVEL = FIFO_AE_LEVEL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    output logic [PTR_W-1:0] count,
    output logic             empty,
    output logic             almost_empty
);

    localparam logic [PTR_W-1:0] FULL = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AE   = PTR_W'(AE_LEVEL);

    logic [PTR_W-1:0] count_q, count_d;
    logic             empty_q, ae_q;

    always_comb begin
        count_d = count_q;
        if (inc && !dec && count_q != FULL) begin
            count_d = count_q + 1'b1;
        end else if (dec && !inc && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            empty_q <= 1'b1;
            ae_q    <= 1'b1;
        end else begin
            count_q <= count_d;
            empty_q <= (count_d == '0);
            ae_q    <= (count_d <= AE);
        end
    end

    assign count        = count_q;
    assign empty        = empty_q;
    assign almost_empty = ae_q;

    // The write side must never push into a full FIFO without a matching read.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(inc && !dec && count_q == FULL));

endmodule

// File: rtl/fifo_output_control.sv
// Read-side FIFO controller: accepts/rejects reads, drives array read enable/address, flags underflow.
// Latency: read_en at edge N -> read_en_o/ptr registered at N+1, data_valid RD_LAT cycles later.
// Backpressure: none; a read at zero occupancy is dropped and latched as underflow.
module fifo_output_control
    import fifo_pkg::*;
#(
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int PTR_W    = FIFO_PTR_W,
    parameter int RD_LAT   = 1,
    parameter int AE_LEVEL = FIFO_AE_LEVEL
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             read_en,
    input  logic             wr_push,
    output logic             read_en_o,
    output logic [PTR_W-1:0] ptr,
    output logic             data_valid,
    output logic             underflow,
    output logic             empty,
    output logic             almost_empty,
    output logic [PTR_W-1:0] count
);

    fifo_state_e       state_q;
    logic              read_en_o_q;
    logic [PTR_W-1:0]  ptr_q;
    logic              underflow_q;
    logic [RD_LAT-1:0] dv_q;
    logic              accept, reject;

    // A push this cycle is not yet readable, so acceptance depends on registered count only.
    assign accept = read_en && (count != '0);
    assign reject = read_en && (count == '0);

    fifo_occupancy_counter #(
        .DEPTH    (DEPTH),
        .PTR_W    (PTR_W),
        .AE_LEVEL (AE_LEVEL)
    ) u_occ (
        .clk          (clk),
        .reset        (reset),
        .inc          (wr_push),
        .dec          (accept),
        .count        (count),
        .empty        (empty),
        .almost_empty (almost_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            read_en_o_q <= 1'b0;
            ptr_q       <= '0;
            underflow_q <= 1'b0;
        end else begin
            read_en_o_q <= accept;
            // ptr shows the address being read while read_en_o is high, then advances.
            ptr_q       <= ptr_q + PTR_W'(read_en_o_q);
            if (accept) begin
                underflow_q <= 1'b0;
            end else if (reject) begin
                underflow_q <= 1'b1;
            end
            unique case (state_q)
                EMPTY: begin
                    if (wr_push)     state_q <= ACTIVE;
                    else if (reject) state_q <= UNDER;
                end
                UNDER: begin
                    if (wr_push) state_q <= ACTIVE;
                end
                ACTIVE: begin
                    if (accept && !wr_push && count == PTR_W'(1)) state_q <= EMPTY;
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dv_q <= '0;
        end else begin
            dv_q[0] <= read_en_o_q;
            for (int i = 1; i < RD_LAT; i++) begin
                dv_q[i] <= dv_q[i-1];
            end
        end
    end

    assign read_en_o  = read_en_o_q;
    assign ptr        = ptr_q;
    assign underflow  = underflow_q;
    assign data_valid = dv_q[RD_LAT-1];

    a_state_count: assert property (@(posedge clk) disable iff (reset)
        (state_q == ACTIVE) == (count != '0));

endmodule

// File: tb/tb_fifo_output_control.sv
// Self-checking bench for fifo_output_control: vector table, directed corner sequences,
// constrained random traffic, with a scoreboard queue of expected read addresses.
module tb_fifo_output_control;
    import fifo_pkg::*;

    logic       clk = 1'b0;
    logic       reset, read_en, wr_push;
    logic       read_en_o, data_valid, underflow, empty, almost_empty;
    logic [4:0] ptr, count;

    fifo_output_control dut (
        .clk          (clk),
        .reset        (reset),
        .read_en      (read_en),
        .wr_push      (wr_push),
        .read_en_o    (read_en_o),
        .ptr          (ptr),
        .data_valid   (data_valid),
        .underflow    (underflow),
        .empty        (empty),
        .almost_empty (almost_empty),
        .count        (count)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    int         m_cnt;
    logic [4:0] m_addr;
    logic       m_uf, m_reo, m_dv;
    logic [4:0] addr_q[$];

    typedef struct {
        logic       rd, push;
        logic       reo;
        logic [4:0] ptr;
        logic       uf;
        logic [4:0] cnt;
        logic       emp, ae, dv;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt  = 0;
        m_addr = '0;
        m_uf   = 1'b0;
        m_reo  = 1'b0;
        m_dv   = 1'b0;
        addr_q.delete();
    endtask

    // One clock: drive, advance the reference model, then sample 1 time unit after the edge.
    task automatic cycle(input logic rd, input logic push);
        logic acc;
        read_en = rd;
        wr_push = push;
        acc = rd && (m_cnt > 0);
        if (acc) begin
            addr_q.push_back(m_addr);
            m_addr = m_addr + 5'd1;
        end
        m_dv  = m_reo;
        m_reo = acc;
        if (rd) m_uf = !acc;
        if (push && !acc && m_cnt < FIFO_DEPTH) m_cnt++;
        else if (acc && !push)                  m_cnt--;
        @(posedge clk);
        #1;
        chk("read_en_o", read_en_o, m_reo);
        if (read_en_o) begin
            if (addr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected_read actual=ptr%0d expected=no_read", ptr);
            end else begin
                chk("ptr_read", ptr, addr_q.pop_front());
            end
        end else begin
            chk("ptr_idle", ptr, m_addr);
        end
        chk("count", count, m_cnt);
        chk("empty", empty, int'(m_cnt == 0));
        chk("almost_empty", almost_empty, int'(m_cnt <= FIFO_AE_LEVEL));
        chk("underflow", underflow, m_uf);
        chk("data_valid", data_valid, m_dv);
    endtask

    task automatic do_reset(input logic rd, input logic push);
        reset   = 1'b1;
        read_en = rd;
        wr_push = push;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_read_en_o", read_en_o, 0);
        chk("rst_ptr", ptr, 0);
        chk("rst_data_valid", data_valid, 0);
        chk("rst_underflow", underflow, 0);
        chk("rst_empty", empty, 1);
        chk("rst_almost_empty", almost_empty, 1);
        chk("rst_count", count, 0);
        reset   = 1'b0;
        read_en = 1'b0;
        wr_push = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        reset   = 1'b1;
        read_en = 1'b0;
        wr_push = 1'b0;
        model_reset();

        //          rd    push  reo   ptr    uf    cnt    emp   ae    dv
        vecs[0] = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd2, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd2, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 5'd1, 1'b0, 5'd1, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 5'd2, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 5'd3, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0};

        do_reset(1'b0, 1'b0);

        // Three writes then three back-to-back reads.
        for (int i = 0; i < 8; i++) begin
            cycle(vecs[i].rd, vecs[i].push);
            chk($sformatf("tbl%0d_reo", i), read_en_o, vecs[i].reo);
            chk($sformatf("tbl%0d_ptr", i), ptr, vecs[i].ptr);
            chk($sformatf("tbl%0d_uf", i), underflow, vecs[i].uf);
            chk($sformatf("tbl%0d_cnt", i), count, vecs[i].cnt);
            chk($sformatf("tbl%0d_empty", i), empty, vecs[i].emp);
            chk($sformatf("tbl%0d_ae", i), almost_empty, vecs[i].ae);
            chk($sformatf("tbl%0d_dv", i), data_valid, vecs[i].dv);
        end

        // Underflow, then a write and a read one cycle later clears it.
        cycle(1'b1, 1'b0);
        chk("uf_set", underflow, 1);
        chk("uf_no_read", read_en_o, 0);
        cycle(1'b0, 1'b1);
        chk("uf_held", underflow, 1);
        cycle(1'b1, 1'b0);
        chk("uf_clear", underflow, 0);
        chk("uf_read_ok", read_en_o, 1);
        cycle(1'b0, 1'b0);

        // Fill to 16, drain, then one more write/read across the pointer wrap.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1);
        chk("full_count", count, 16);
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0);
        chk("drained_count", count, 0);
        chk("ptr_before_wrap", ptr, 5'h0F);
        cycle(1'b0, 1'b0);
        chk("ptr_wrapped", ptr, 5'h10);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        chk("wrap_read_ptr", ptr, 5'h10);
        cycle(1'b0, 1'b0);
        chk("ptr_after_wrap", ptr, 5'h11);

        // Simultaneous push and read at count 5, then at count 0.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        chk("sim5_count", count, 5);
        chk("sim5_reo", read_en_o, 1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0);
        chk("sim0_pre", count, 0);
        cycle(1'b1, 1'b1);
        chk("sim0_count", count, 1);
        chk("sim0_uf", underflow, 1);
        chk("sim0_reo", read_en_o, 0);

        // Almost-empty threshold crossing.
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        chk("ae_at3", almost_empty, 0);
        cycle(1'b1, 1'b0);
        chk("ae_at2", almost_empty, 1);
        chk("ae_cnt2", count, 2);

        // Reset during a read burst at count 8 drops in-flight data_valid.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);

        // Random traffic, never pushing into a full FIFO without a read.
        for (int i = 0; i < 300; i++) begin
            logic rd, push;
            rd   = 1'($urandom_range(0, 1));
            push = 1'($urandom_range(0, 1));
            if (m_cnt >= FIFO_DEPTH && !rd) push = 1'b0;
            cycle(rd, push);
        end
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        chk("sb_drained", addr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_output_control.md
# fifo_output_control

Read-side controller for the 16-entry synchronous FIFO, the counterpart of the write-side input controller. It tracks occupancy from the write side's accepted-write strobe, accepts or rejects read requests, drives the storage array's read enable and read address, flags underflow, and marks returned data valid after the array's read latency. It sits between the FIFO storage array and the downstream consumer.

## Interface
Parameters:
- DEPTH, 16: number of storage entries; power of two.
- PTR_W, 5: pointer width, log2(DEPTH)+1; MSB is the wrap bit.
- RD_LAT, 1: storage read latency in cycles, 1 or 2.
- AE_LEVEL, 2: almost-empty threshold in entries.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high.
- read_en, input, 1: consumer read request, sampled each rising edge.
- wr_push, input, 1: one-cycle pulse from the write side per accepted write (its registered write enable).
- read_en_o, output, 1: storage read enable, high for one cycle per accepted read.
- ptr, output, PTR_W: read pointer; low log2(DEPTH) bits are the storage address.
- data_valid, output, 1: storage read data is valid this cycle.
- underflow, output, 1: last read request was rejected because the FIFO was empty.
- empty, output, 1: occupancy is 0.
- almost_empty, output, 1: occupancy is at most AE_LEVEL.
- count, output, PTR_W: current occupancy, 0..DEPTH.

## Operation
- State machine with three states:
  - EMPTY: count 0.
  - ACTIVE: count 1..DEPTH.
  - UNDER: count 0 and a rejected read is outstanding.
- A read is accepted when read_en=1 and count>0 at the sampling edge. On acceptance:
  - read_en_o=1 next cycle, with ptr holding the address being read.
  - ptr increments after that cycle.
  - count decrements.
  - underflow clears.
- A read is rejected when read_en=1 and count=0:
  - underflow=1, read_en_o=0, ptr unchanged, state goes to UNDER.
  - underflow stays high until the next accepted read or reset.
- wr_push=1 increments count.
- Simultaneous wr_push and an accepted read: count unchanged.
- Simultaneous wr_push and read_en at count 0: the read is rejected (data not yet readable), underflow=1, count becomes 1, state goes to ACTIVE.
- wr_push at count=DEPTH: the write side guarantees this never happens. If it does anyway, count saturates at DEPTH (checked by an assertion).
- Pointer arithmetic is modulo 2^PTR_W:
  - The address wraps from DEPTH-1 to 0 and the MSB toggles.
  - The address is never reset except by reset.
- Transitions:
  - EMPTY to ACTIVE on wr_push; EMPTY to UNDER on a rejected read.
  - UNDER to ACTIVE on wr_push; UNDER stays in UNDER on a further rejected read.
  - ACTIVE to EMPTY when the last entry is read with no simultaneous wr_push.
- read_en=0: read_en_o=0, all else held apart from count updates from wr_push.

## Timing
- All outputs are registered. No combinational path from inputs to outputs.
- Reset values: read_en_o=0, ptr=0, data_valid=0, underflow=0, empty=1, almost_empty=1, count=0, state EMPTY. The data_valid pipeline is cleared.
- Read latency:
  - read_en sampled at edge N gives read_en_o and ptr at N+1.
  - data_valid follows read_en_o at N+1+RD_LAT.
  - Sustained throughput is one read per cycle.
- empty, almost_empty and count reflect the state after edge N's updates and are visible from N+1.
- Reset asserted mid-operation overrides every other input on that edge. In-flight data_valid pulses are dropped and not emitted after reset.
- read_en is a level request, not a handshake. Each high cycle is one independent request.

## Structure
- The shared package fifo_pkg holds:
  - DEPTH, PTR_W and AE_LEVEL defaults.
  - State encoding EMPTY=2'd0, ACTIVE=2'd1, UNDER=2'd2.
  - The write side includes the same constants.
- One sub-module, fifo_occupancy_counter:
  - Inputs: inc, dec, reset.
  - Outputs: count, empty, almost_empty.
  - Saturates at DEPTH.
- The RD_LAT-deep data_valid shift register is inline.

## Test plan
- Reset, then 3 wr_push pulses, then read_en high 3 cycles:
  - read_en_o high 3 cycles with ptr 0,1,2.
  - data_valid follows RD_LAT later.
  - count goes 3 to 0, empty=1.
- read_en at count 0: underflow=1 and read_en_o=0. Then wr_push and read_en one cycle later: read accepted and underflow clears.
- 16 writes, then 16 reads, then 1 write and 1 read:
  - ptr goes 0x0F to 0x10 with the address wrapping to 0 and the MSB set.
  - count reaches 16 then 0.
- wr_push and read_en in the same cycle:
  - At count 5: count stays 5 and read_en_o=1.
  - At count 0: count becomes 1 and underflow=1.
- At count 3, almost_empty=0. Read once: almost_empty=1 at count 2.
- Reset during a read burst at count 8: next cycle all outputs at reset values and no data_valid pulse after reset.
